// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES sequencer, one Feistel round per clock through an external f-function
// Ports: clk, rst (sync, active-high); start, enc_dec, in, key request one block;
//   f_r, f_k feed the external f-function and f_out returns its result in the same cycle;
//   busy while rounds run, done pulses when out is updated, key_err pulses on a parity reject.
// Optional feature: define DES_KEY_PARITY_EN to reject keys whose bytes lack odd parity.
module des_iter_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        enc_dec,
  input  logic [1:64] in,
  input  logic [1:64] key,
  output logic [1:32] f_r,
  output logic [1:48] f_k,
  input  logic [1:32] f_out,
  output logic        busy,
  output logic        done,
  output logic [1:64] out,
  output logic        key_err
);
  localparam int ip_t [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};
  localparam int fp_t [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41, 9, 49, 17, 57, 25};
  localparam int pc1_t [1:56] = '{
    57, 49, 41, 33, 25, 17, 9,
    1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
    7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29,
    21, 13, 5, 28, 20, 12, 4};
  localparam int pc2_t [1:48] = '{
    14, 17, 11, 24, 1, 5,
    3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8,
    16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};
  function automatic logic [1:64] ip(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[ip_t[i]];
    return y;
  endfunction
  function automatic logic [1:64] fp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[fp_t[i]];
    return y;
  endfunction
  function automatic logic [1:56] pc1(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 1; i <= 56; i++) y[i] = x[pc1_t[i]];
    return y;
  endfunction
  function automatic logic [1:48] pc2(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[pc2_t[i]];
    return y;
  endfunction
  function automatic logic [1:28] r28(input logic [1:28] x, input logic left, input logic two);
    return left ? (two ? {x[3:28], x[1:2]} : {x[2:28], x[1]})
                : (two ? {x[27:28], x[1:26]} : {x[28], x[1:27]});
  endfunction
  typedef enum logic {IDLE, ROUND} state_t;
  state_t      state, nxt;
  logic [4:0]  rnd;
  logic        mode;
  logic [1:32] l, r;
  logic [1:56] cd;
  logic [1:56] pk;
  logic        accept, last, two, key_ok;
  assign pk     = pc1(key);
  assign accept = state == IDLE && start && key_ok;
  assign last   = rnd == 5'd16;
  // the shift that prepares round rnd+1; single shifts precede rounds 2, 9 and 16
  assign two    = !(rnd == 5'd1 || rnd == 5'd8 || rnd == 5'd15);
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (accept ? ROUND : IDLE) : (last ? IDLE : ROUND);
  always_comb begin
    busy = state == ROUND;
    f_r  = r;
    f_k  = pc2(cd);
  end
  // cd holds the already-rotated {C',D'} of the round in progress, so f_k is wiring off a register
  always_ff @(posedge clk)
    if (rst) begin
      rnd  <= '0;
      mode <= 1'b0;
      l    <= '0;
      r    <= '0;
      cd   <= '0;
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= busy && last;
      if (accept) begin
        {l, r} <= ip(in);
        cd     <= enc_dec ? {r28(pk[1:28], 1'b1, 1'b0), r28(pk[29:56], 1'b1, 1'b0)} : pk;
        mode   <= enc_dec;
        rnd    <= 5'd1;
      end else if (busy) begin
        l   <= r;
        r   <= l ^ f_out;
        cd  <= {r28(cd[1:28], mode, two), r28(cd[29:56], mode, two)};
        rnd <= rnd + 5'd1;
        if (last) out <= fp({l ^ f_out, r});
      end
    end
`ifdef DES_KEY_PARITY_EN
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) key_ok = key_ok & (^key[8*b+1 +: 8]);
  end
  always_ff @(posedge clk)
    key_err <= rst ? 1'b0 : state == IDLE && start && !key_ok;
`else
  logic unused_parity;
  assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};
  assign key_ok  = 1'b1;
  assign key_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: bench for des_iter_ctrl with a reference DES model and the f-function unit
module tb_des_iter_ctrl;
  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [1:48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [1:48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [1:32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int SH [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [0:7][0:63] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  localparam logic [1:64] K1  = 64'h133457799BBCDFF1;
  localparam logic [1:64] K1P = 64'h123457799BBCDFF1;
  localparam logic [1:64] WK  = 64'h0101010101010101;
  localparam logic [1:64] P1  = 64'h0123456789ABCDEF;
  localparam logic [1:64] C1  = 64'h85E813540F0AB405;
  localparam logic [1:64] CW  = 64'h8CA64DE9C1B123A7;
  function automatic logic [1:48] sub_key(input logic [1:64] k, input int n);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] o;
    for (int i = 1; i <= 56; i++) cd[i] = k[PC1_T[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int i = 1; i <= n; i++) begin
      c = (c << SH[i]) | (c >> (28 - SH[i]));
      d = (d << SH[i]) | (d >> (28 - SH[i]));
    end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) o[i] = cd[PC2_T[i]];
    return o;
  endfunction
  function automatic logic [1:32] ffun(input logic [1:32] rr, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s, p;
    logic [5:0] six;
    int v;
    for (int i = 1; i <= 48; i++) x[i] = rr[E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[6*b+1 +: 6];
      v = SB[b][16 * int'({six[5], six[0]}) + int'(six[4:1])];
      s[4*b+1 +: 4] = v[3:0];
    end
    for (int i = 1; i <= 32; i++) p[i] = s[P_T[i]];
    return p;
  endfunction
  function automatic logic [1:64] des(input logic [1:64] x, input logic [1:64] k, input logic e);
    logic [1:64] y, z;
    logic [1:32] lh, rh, t;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
    lh = y[1:32];
    rh = y[33:64];
    for (int i = 1; i <= 16; i++) begin
      t  = rh;
      rh = lh ^ ffun(rh, sub_key(k, e ? i : 17 - i));
      lh = t;
    end
    y = {rh, lh};
    for (int i = 1; i <= 64; i++) z[i] = y[FP_T[i]];
    return z;
  endfunction
  function automatic bit par_bad(input logic [1:64] k);
`ifdef DES_KEY_PARITY_EN
    for (int b = 0; b < 8; b++) if ($countones(k[8*b+1 +: 8]) % 2 == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction
  logic clk = 1'b0, rst, start, enc_dec;
  logic [1:64] in, key, out;
  logic [1:32] f_r, f_out;
  logic [1:48] f_k;
  logic busy, done, key_err;
  int n_cmp = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign f_out = ffun(f_r, f_k);
  des_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .enc_dec(enc_dec), .in(in), .key(key),
    .f_r(f_r), .f_k(f_k), .f_out(f_out), .busy(busy), .done(done), .out(out), .key_err(key_err));
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask
  bit live = 1'b0;
  bit m_busy, m_done, m_kerr, m_enc;
  int m_left;
  logic [1:64] m_out, m_res, m_key;
  always @(posedge clk)
    if (rst) begin
      live <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_kerr <= 1'b0; m_out <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_kerr <= 1'b0;
      if (!m_busy) begin
        if (start && par_bad(key)) m_kerr <= 1'b1;
        else if (start) begin
          m_busy <= 1'b1; m_left <= 16; m_enc <= enc_dec; m_key <= key; m_res <= des(in, key, enc_dec);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_out <= m_res;
        end
      end
    end
  always @(negedge clk)
    if (live && !rst) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("out", out, m_out);
      chk("key_err", 64'(key_err), 64'(m_kerr));
      if (m_busy) chk("f_k", 64'(f_k), 64'(sub_key(m_key, m_enc ? 17 - m_left : m_left)));
    end
  task automatic go(input logic e, input logic [1:64] k, input logic [1:64] x);
    @(posedge clk);
    #2 start = 1'b1; enc_dec = e; key = k; in = x;
    @(posedge clk);
    #2 start = 1'b0;
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clk);
      #1 n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, nb, nd, t1, t2;
    rst = 1'b1; start = 1'b0; enc_dec = 1'b0; in = '0; key = '0;
    chk("model_enc", des(P1, K1, 1'b1), C1);
    chk("model_dec", des(C1, K1, 1'b0), P1);
    chk("model_weak", des('0, WK, 1'b1), CW);
    chk("model_k1", 64'(sub_key(K1, 1)), 64'h1B02EFFC7072);
    chk("model_k16", 64'(sub_key(K1, 16)), 64'hCB3D8B0E17F5);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", out, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    go(1'b1, K1, P1);
    wait_done(n, nb);
    chk("enc_lat", 64'(n), 64'd16);
    chk("enc_busy_cycles", 64'(nb), 64'd16);
    chk("enc_out", out, C1);
    go(1'b0, K1, C1);
    wait_done(n, nb);
    chk("dec_lat", 64'(n), 64'd16);
    chk("dec_out", out, P1);
    @(posedge clk);
    #2 start = 1'b1; enc_dec = 1'b1; key = K1; in = P1;
    wait_done(n, nb);
    t1 = cyc;
    chk("b2b_out1", out, C1);
    enc_dec = 1'b0; in = C1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    t2 = cyc;
    chk("b2b_gap", 64'(t2 - t1), 64'd17);
    chk("b2b_out2", out, P1);
    go(1'b1, WK, '0);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; in = '1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(n, nb);
    chk("weak_out", out, CW);
    go(1'b1, K1, P1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out", out, 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    #1 rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'h0);
    go(1'b1, K1, P1);
    wait_done(n, nb);
    chk("after_abort_out", out, C1);
    go(1'b1, K1P, P1);
`ifdef DES_KEY_PARITY_EN
    chk("par_key_err", 64'(key_err), 64'h1);
    chk("par_busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1 chk("par_pulse_end", 64'(key_err), 64'h0);
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done || busy) nd++;
    end
    chk("par_no_run", 64'(nd), 64'h0);
    chk("par_out_kept", out, C1);
`else
    chk("nopar_key_err", 64'(key_err), 64'h0);
    wait_done(n, nb);
    chk("nopar_lat", 64'(n), 64'd16);
    chk("nopar_out", out, C1);
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/des_iter_ctrl.md
# des_iter_ctrl

Iterative DES sequencer that runs one 64-bit block through 16 Feistel rounds, one round per clock, using a single external combinational f-function unit. It owns IP/FP, the L/R registers, the round counter and the on-the-fly key schedule (PC-1, rotations, PC-2). A valid/done handshake lets it replace the fully unrolled combinational DES core wherever area matters more than latency. Bit numbering is DES-standard `[1:64]`, with bit 1 as the MSB.

## Interface
- No parameters. Behaviour is fixed by the DES standard and the one macro described under Configuration.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to process one block; sampled only in IDLE.
- `enc_dec`  in  1  `1` = encrypt, `0` = decrypt; sampled with `start`.
- `in`  in  `[1:64]`  plaintext or ciphertext; sampled with `start`.
- `key`  in  `[1:64]`  64-bit key including parity bits; sampled with `start`.
- `f_r`  out  `[1:32]`  current R half, sent to the f-function.
- `f_k`  out  `[1:48]`  current round subkey, sent to the f-function.
- `f_out`  in  `[1:32]`  f(`f_r`, `f_k`) result, combinational in the same cycle.
- `busy`  out  1  high while rounds execute.
- `done`  out  1  one-cycle pulse when `out` is updated.
- `out`  out  `[1:64]`  result; holds its value until the next completion.
- `key_err`  out  1  one-cycle pulse on a key parity reject; constant 0 when the feature is compiled out.

## Operation
- States:
  - IDLE, then ROUND via accepted `start`.
  - ROUND, then IDLE after round 16.
  - IDLE, then IDLE when a start is rejected for key parity.
- Accept edge (IDLE and `start`=1):
  - Load {L,R} <= IP(`in`).
  - Load {C,D} <= PC-1(`key`).
  - Latch `enc_dec`; set `rnd` <= 1; enter ROUND.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt, round i: {C',D'} = {C,D} each rotated left by s[i].
- Decrypt, round i: {C',D'} = {C,D} each rotated right by r[i], where r[1]=0 and r[i]=s[i] for i≥2.
- Every round: `f_k` = PC-2(C',D'); `f_r` = R.
- Each ROUND edge:
  - L <= R; R <= L ^ `f_out`; {C,D} <= {C',D'}.
  - `rnd` <= `rnd`+1.
- After round 16:
  - `out` <= FP(R16‖L16), with the halves swapped.
  - `done` <= 1; return to IDLE.
- `start` is ignored while `busy`=1. No queuing, no error.
- After 16 rounds {C,D} has rotated 28 positions and is back to PC-1(`key`). This is why decrypt starts from an unrotated state.
- Reset values: state IDLE, `rnd`=0, `busy`=0, `done`=0, `key_err`=0, `out`=64'h0. L, R, C and D are cleared to 0.
- Reset during ROUND aborts immediately:
  - no `done` pulse;
  - `out` cleared;
  - the next `start` is accepted normally.

## Timing
- Call the accept edge E0. Rounds 1..16 execute on edges E1..E16.
- `busy`: high after E0, low after E16.
- `done` and `out`: become valid after E16, i.e. 16 cycles after acceptance. `done` drops after E17.
- Throughput is one block per 17 cycles.
- `start` held high in the cycle where `done`=1 is accepted at E17. Back-to-back blocks therefore start every 17 cycles.
- `f_r` and `f_k` are driven from registers plus wiring only: no added logic depth before the f-function.
- `f_out` must settle within the same cycle.

## Configuration
- Macro `DES_KEY_PARITY_EN`.
- When defined:
  - On an IDLE `start`, each key byte must have odd parity.
  - On any violation, `key_err` pulses for one cycle after E0.
  - State stays IDLE; `busy` and `done` stay low; `out` is unchanged.
- When undefined:
  - Parity bits are ignored.
  - `key_err` is tied to 0.

## Test plan
- Encrypt: `key`=133457799BBCDFF1, `in`=0123456789ABCDEF, `enc_dec`=1. Expect `done` exactly 16 cycles after acceptance with `out`=85E813540F0AB405, and `busy` high for exactly 16 cycles.
- Decrypt: same key, `in`=85E813540F0AB405, `enc_dec`=0. Expect `out`=0123456789ABCDEF. Then issue back-to-back encrypt and decrypt with `start` held through `done`; the second `done` comes 17 cycles after the first.
- Encrypt: `key`=0101010101010101, `in`=0000000000000000. Expect `out`=8CA64DE9C1B123A7. While `busy`, pulse `start` with a different `in`; expect no effect on `out`.
- Assert `rst` at round 8 of an encrypt. Expect no `done`, and `out`=0, `busy`=0 on the next cycle. A fresh `start` then gives the correct 85E813540F0AB405.
- With `DES_KEY_PARITY_EN`: `key`=123457799BBCDFF1.
  - Expect a `key_err` pulse, no `busy`, no `done`, and `out` unchanged.
  - Without the macro, the same key encrypts normally and `key_err` stays 0.
